// File: rtl/res_overlay_pkg.sv
// rtl/res_overlay_pkg.sv - shared video defines, mode struct and overlay reader types
`ifndef RESLINE_SIZE
`define RESLINE_SIZE 32
`endif
`ifndef MODE_480p60
`define MODE_480p60  4'd0
`endif
`ifndef MODE_576p50
`define MODE_576p50  4'd1
`endif
`ifndef MODE_720p60
`define MODE_720p60  4'd2
`endif
`ifndef MODE_1080p60
`define MODE_1080p60 4'd3
`endif

package res_overlay_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [11:0] h_active;
        logic [11:0] v_active;
    } VideoMode;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CAPTURE,
        SHIFT
    } res_state_e;

    // ROM address goes out this many pixels before the first box pixel
    localparam int RES_PREFETCH = 3;

endpackage

// File: rtl/res_line_shifter.sv
// rtl/res_line_shifter.sv - bitmap line shift register with per-bit pixel replication
module res_line_shifter #(
    parameter int WIDTH      = 32,
    parameter int SCALE_LOG2 = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    localparam int CNTW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [CNTW-1:0] REP_MAX = CNTW'((1 << SCALE_LOG2) - 1);

    logic [WIDTH-1:0] shreg_q;
    logic [CNTW-1:0]  rep_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            rep_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            rep_q   <= '0;
        end else if (advance_i) begin
            if (rep_q == REP_MAX) begin
                rep_q   <= '0;
                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                rep_q <= rep_q + CNTW'(1);
            end
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/res_overlay_reader.sv
// rtl/res_overlay_reader.sv - resolution label ROM reader and pixel serialiser
// Optional 1-pixel frame around the box: RES_OVERLAY_BORDER_EN.
module res_overlay_reader
    import res_overlay_pkg::*;
#(
    parameter int X0         = 16,
    parameter int Y0         = 16,
    parameter int SCALE_LOG2 = 0,
    parameter int CW         = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  VideoMode                 videoMode,
    input  logic [CW-1:0]            counterX,
    input  logic [CW-1:0]            counterY,
    output logic [3:0]               rom_addr,
    input  logic [`RESLINE_SIZE-1:0] rom_q,
    output logic                     pixel_on,
    output logic                     in_box
);

    localparam int W = `RESLINE_SIZE << SCALE_LOG2;
    localparam int H = 16 << SCALE_LOG2;
    localparam logic [CW-1:0] X_LO    = CW'(X0);
    localparam logic [CW-1:0] X_END   = CW'(X0 + W);
    localparam logic [CW-1:0] X_LAST  = CW'(X0 + W - 1);
    localparam logic [CW-1:0] X_FETCH = CW'(X0 - RES_PREFETCH);
    localparam logic [CW-1:0] Y_LO    = CW'(Y0);
    localparam logic [CW-1:0] Y_END   = CW'(Y0 + H);

    res_state_e    state_q, state_d;
    logic [3:0]    rom_addr_q, rom_addr_d;
    logic [CW-1:0] x_q;
    logic [3:0]    id_q;
    logic          lock_q, lock_d;
    logic [CW-1:0] lock_y_q, lock_y_d;
    logic          load, advance, bit_msb;

    logic unused_mode;
    assign unused_mode = ^{videoMode.h_active, videoMode.v_active};

    logic       in_v, in_h, box, busy, abort, fetch;
    logic [3:0] row;

    assign in_v  = (counterY >= Y_LO) && (counterY < Y_END);
    assign in_h  = (counterX >= X_LO) && (counterX < X_END);
    assign box   = in_v && in_h;
    assign row   = 4'((counterY - Y_LO) >> SCALE_LOG2);
    assign busy  = (state_q != IDLE);
    // Any break in the pixel stream or mode switch invalidates the line in flight
    assign abort = busy && ((counterX != x_q + CW'(1)) || (videoMode.id != id_q));
    assign fetch = (counterX == X_FETCH) && in_v && !(lock_q && (counterY == lock_y_q));

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        lock_d     = lock_q && (counterY == lock_y_q);
        lock_y_d   = lock_y_q;
        load       = 1'b0;
        advance    = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            lock_d   = 1'b1;
            lock_y_d = counterY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch) begin
                        rom_addr_d = row;
                        state_d    = ADDR;
                    end
                end
                ADDR:    state_d = CAPTURE;
                CAPTURE: begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    advance = 1'b1;
                    if (counterX == X_LAST) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            x_q        <= '0;
            id_q       <= '0;
            lock_q     <= 1'b0;
            lock_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            x_q        <= counterX;
            id_q       <= videoMode.id;
            lock_q     <= lock_d;
            lock_y_q   <= lock_y_d;
        end
    end

    res_line_shifter #(
        .WIDTH      (`RESLINE_SIZE),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .load_i    (load),
        .advance_i (advance),
        .data_i    (rom_q),
        .msb_o     (bit_msb)
    );

    logic bitmap_on, frame_on;
    assign bitmap_on = (state_q == SHIFT) && !abort && bit_msb && box;

`ifdef RES_OVERLAY_BORDER_EN
    localparam logic [CW-1:0] X_FL = CW'(X0 - 1);
    localparam logic [CW-1:0] Y_FL = CW'(Y0 - 1);
    assign frame_on = (counterX >= X_FL) && (counterX <= X_END) &&
                      (counterY >= Y_FL) && (counterY <= Y_END) && !box;
`else
    assign frame_on = 1'b0;
`endif

    assign rom_addr = rom_addr_q;
    assign in_box   = box && !reset;
    assign pixel_on = (bitmap_on || frame_on) && !reset;

endmodule

// File: doc/res_overlay_reader.md
Name: res_overlay_reader

Overview:
- Reads the resolution-label character ROM: generates the 4-bit row address, captures the returned RESLINE_SIZE-bit bitmap line and serialises it into a per-pixel overlay bit.
- Sits between the video timing counters and the output pixel mux.
- Draws the current mode's resolution label as a box at a fixed screen position, with optional integer pixel scaling.

Parameters:
- X0, 16: left edge of label box in active pixels. Must be >= 3.
- Y0, 16: top edge of label box in active lines.
- SCALE_LOG2, 0: pixel/line replication factor is 2**SCALE_LOG2. Allowed range 0..2.
- CW, 12: width of the counterX/counterY inputs.

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- videoMode  in  VideoMode  current mode struct; only .id is used
- counterX  in  CW  active-area pixel counter, 0 at first active pixel
- counterY  in  CW  active-area line counter
- rom_addr  out  4  row address to the ROM, registered
- rom_q  in  `RESLINE_SIZE  ROM line data, valid 1 clock after rom_addr
- pixel_on  out  1  overlay bit for the pixel at the current counterX/counterY
- in_box  out  1  current pixel lies inside the label box

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - rom_addr=0, pixel_on=0, in_box=0
  - shift register cleared, state=IDLE, replication counter=0
- Box geometry:
  - W = `RESLINE_SIZE << SCALE_LOG2
  - H = 16 << SCALE_LOG2
  - Inside box: X0 <= counterX < X0+W and Y0 <= counterY < Y0+H
  - row = (counterY-Y0) >> SCALE_LOG2, width 4
- FSM states: IDLE, ADDR, CAPTURE, SHIFT.
  - IDLE -> ADDR: when counterX == X0-3 and counterY is inside the vertical box range. rom_addr<=row is registered in this cycle.
  - ADDR -> CAPTURE: unconditional, one cycle. ROM is reading.
  - CAPTURE -> SHIFT: shreg<=rom_q. The cycle after capture, counterX == X0.
  - SHIFT:
    - pixel_on = shreg[MSB] & in_box.
    - Replication counter runs 0..2**SCALE_LOG2-1; shreg shifts left, zero-filled, on each counter wrap.
    - Return to IDLE when counterX == X0+W-1.
- Latency: pixel_on and in_box are combinational from registered state, i.e. zero latency relative to counterX.
- Bit order: bit `RESLINE_SIZE-1 is the leftmost pixel.
- counterX not advancing by 1 per clock (blanking, or counter jump) while in ADDR, CAPTURE or SHIFT:
  - Abort to IDLE with pixel_on=0.
  - No re-fetch on that line.
- videoMode.id change while not IDLE:
  - Abort to IDLE.
  - The next qualifying line fetches the new mode's data.
  - No stale bits are emitted after the change cycle.
- Outside the vertical range: FSM stays IDLE; rom_addr holds its last value.
- The last box line is row 15. counterY = Y0+H gives no fetch.
- Reset asserted mid-line: outputs clear immediately. The FSM restarts at the next qualifying X0-3.

Optional Feature:
- Macro: RES_OVERLAY_BORDER_EN.
- When defined:
  - pixel_on is also 1 on a 1-pixel frame just outside the box: counterX==X0-1 or X0+W, or counterY==Y0-1 or Y0+H, within the box span extended by 1.
  - Requires X0>=4 and Y0>=1.
- When undefined: no frame logic; pixel_on comes only from bitmap bits.

Decomposition:
- VideoMode struct, `MODE_* ids and `RESLINE_SIZE stay in the shared defines package.
- Add to that package:
  - the FSM state enum
  - the prefetch distance constant RES_PREFETCH=3
- One natural sub-module: res_line_shifter. It holds the load/shift register and replication counter, driven by load and advance strobes.

Test Plan:
1. Reset asserted during SHIFT at counterX=X0+5 -> pixel_on=0 and in_box=0 in the same cycle; next line renders normally.
2. SCALE_LOG2=0, mode `MODE_720p60, ROM row 0 = 'hA5 in top 8 bits, counterY=Y0 -> rom_addr=0 issued at counterX=X0-3; pixel_on at X0..X0+7 = 1,0,1,0,0,1,0,1.
3. SCALE_LOG2=1, counterY=Y0+3 -> rom_addr=1; each bitmap bit held for 2 pixels; box width 2*`RESLINE_SIZE.
4. counterY=Y0+16 with SCALE_LOG2=0 -> no fetch, pixel_on=0 and in_box=0 across the whole line.
5. videoMode.id switched from `MODE_1080p60 to `MODE_576p50 at counterX=X0+2 -> pixel_on=0 for the rest of that line; next line shows 576p50 data.
6. RES_OVERLAY_BORDER_EN defined, all-zero ROM -> pixel_on=1 only on the frame: X0-1, X0+W, Y0-1, Y0+H.
